// File: rtl/sgd_rd_scheduler.sv
// sgd_rd_scheduler: AR-channel burst sequencer for SGD epochs and mini-batches.
// Each batch issues b (label) bursts tagged TAG_B, then a (sample) bursts tagged TAG_A.
// Issue is limited by an outstanding-burst credit count and by dispatch almost_full.
// Optional feature macro: SGD_RD_PERF_EN enables the AR stall-cycle counter.
module sgd_rd_scheduler #(
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 5,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_A           = 1,
  parameter int TAG_B           = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base_addr,
  input  logic [ADDR_WIDTH-1:0] b_base_addr,
  input  logic [15:0]           a_bursts_per_batch,
  input  logic [15:0]           b_bursts_per_batch,
  input  logic [15:0]           num_batches,
  input  logic [15:0]           num_epochs,
  output logic                  m_axi_ARVALID,
  input  logic                  m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [7:0]            m_axi_ARLEN,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  input  logic                  rsp_fire,
  input  logic                  rsp_last,
  input  logic                  dispatch_almost_full,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            outstanding,
  output logic [31:0]           perf_ar_stall_cycles
);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_LEN * 64);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_B, S_ISSUE_A, S_NEXT_BATCH, S_NEXT_EPOCH, S_DRAIN, S_DONE
  } state_t;

  state_t                r_state, w_nxt;
  logic [ADDR_WIDTH-1:0] r_a_base, r_b_base, r_a_ptr, r_b_ptr, r_araddr;
  logic [15:0]           r_a_cnt, r_b_cnt, r_num_batches, r_num_epochs;
  logic [15:0]           r_batch_cnt, r_epoch_cnt, r_burst_cnt;
  logic [ID_WIDTH-1:0]   r_arid;
  logic                  r_arvalid, r_busy;
  logic [7:0]            r_outstanding;
  logic                  w_hs, w_in_issue, w_issue_done, w_rise, w_rlast;
  logic [15:0]           w_target;
  state_t                w_first;

  assign w_hs         = r_arvalid & m_axi_ARREADY;
  assign w_rlast      = rsp_fire & rsp_last;
  assign w_in_issue   = (r_state == S_ISSUE_B) | (r_state == S_ISSUE_A);
  assign w_target     = (r_state == S_ISSUE_B) ? r_b_cnt : r_a_cnt;
  // A state's quota is complete once the last handshake has retired ARVALID.
  assign w_issue_done = w_in_issue & ~r_arvalid & (r_burst_cnt == w_target);
  assign w_rise       = w_in_issue & ~r_arvalid & (r_burst_cnt < w_target) &
                        (r_outstanding < 8'(MAX_OUTSTANDING)) & ~dispatch_almost_full;
  assign w_first      = (r_b_cnt != 16'd0) ? S_ISSUE_B : S_ISSUE_A;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state sequencing through batches and epochs.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (start) begin
          if (num_epochs == 16'd0 || num_batches == 16'd0) w_nxt = S_DONE;
          else if (b_bursts_per_batch != 16'd0)            w_nxt = S_ISSUE_B;
          else                                             w_nxt = S_ISSUE_A;
        end
      S_ISSUE_B:
        if (w_issue_done) w_nxt = (r_a_cnt == 16'd0) ? S_NEXT_BATCH : S_ISSUE_A;
      S_ISSUE_A:
        if (w_issue_done) w_nxt = S_NEXT_BATCH;
      S_NEXT_BATCH:
        w_nxt = (r_batch_cnt == r_num_batches - 16'd1) ? S_NEXT_EPOCH : w_first;
      S_NEXT_EPOCH:
        w_nxt = (r_epoch_cnt == r_num_epochs - 16'd1) ? S_DRAIN : w_first;
      S_DRAIN:
        if (r_outstanding == 8'd0) w_nxt = S_DONE;
      S_DONE:
        w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  // Config capture, address pointers, loop counters and AR request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_base <= '0; r_b_base <= '0; r_a_ptr <= '0; r_b_ptr <= '0; r_araddr <= '0;
      r_a_cnt <= '0; r_b_cnt <= '0; r_num_batches <= '0; r_num_epochs <= '0;
      r_batch_cnt <= '0; r_epoch_cnt <= '0; r_burst_cnt <= '0;
      r_arid <= '0; r_arvalid <= 1'b0; r_busy <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a_base      <= a_base_addr;
        r_b_base      <= b_base_addr;
        r_a_ptr       <= a_base_addr;
        r_b_ptr       <= b_base_addr;
        r_a_cnt       <= a_bursts_per_batch;
        r_b_cnt       <= b_bursts_per_batch;
        r_num_batches <= num_batches;
        r_num_epochs  <= num_epochs;
        r_batch_cnt   <= '0;
        r_epoch_cnt   <= '0;
        r_burst_cnt   <= '0;
        r_busy        <= 1'b1;
      end
      if (w_rise) begin
        r_arvalid <= 1'b1;
        r_araddr  <= (r_state == S_ISSUE_B) ? r_b_ptr : r_a_ptr;
        r_arid    <= (r_state == S_ISSUE_B) ? ID_WIDTH'(TAG_B) : ID_WIDTH'(TAG_A);
      end else if (w_hs) begin
        r_arvalid   <= 1'b0;
        r_burst_cnt <= r_burst_cnt + 16'd1;
        if (r_state == S_ISSUE_B) r_b_ptr <= r_b_ptr + STRIDE;
        else                      r_a_ptr <= r_a_ptr + STRIDE;
      end
      if (w_in_issue && w_nxt != r_state) r_burst_cnt <= '0;
      if (r_state == S_NEXT_BATCH) r_batch_cnt <= r_batch_cnt + 16'd1;
      if (r_state == S_NEXT_EPOCH) begin
        r_epoch_cnt <= r_epoch_cnt + 16'd1;
        r_batch_cnt <= '0;
        r_a_ptr     <= r_a_base;
        r_b_ptr     <= r_b_base;
      end
      if (r_state == S_DONE) r_busy <= 1'b0;
    end
  end

  // In-flight burst credits; RLASTs of bursts abandoned by reset saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_outstanding <= '0;
    else if (w_hs && !w_rlast) r_outstanding <= r_outstanding + 8'd1;
    else if (!w_hs && w_rlast && r_outstanding != 8'd0) r_outstanding <= r_outstanding - 8'd1;
  end

`ifdef SGD_RD_PERF_EN
  logic [31:0] r_perf;
  logic        w_stall;
  assign w_stall = (r_busy & ~r_arvalid &
                    ((r_outstanding == 8'(MAX_OUTSTANDING)) | dispatch_almost_full)) |
                   (r_arvalid & ~m_axi_ARREADY);

  // Saturating count of cycles where AR issue is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_perf <= '0;
    else if (r_state == S_IDLE && start)          r_perf <= '0;
    else if (w_stall && r_perf != 32'hFFFF_FFFF)  r_perf <= r_perf + 32'd1;
  end
  assign perf_ar_stall_cycles = r_perf;
`else
  assign perf_ar_stall_cycles = 32'd0;
`endif

  assign m_axi_ARVALID = r_arvalid;
  assign m_axi_ARADDR  = r_araddr;
  assign m_axi_ARID    = r_arid;
  assign m_axi_ARLEN   = 8'(BURST_LEN - 1);
  assign m_axi_ARSIZE  = 3'b110;
  assign m_axi_ARBURST = 2'b01;
  assign busy          = r_busy;
  assign done          = (r_state == S_DONE);
  assign outstanding   = r_outstanding;
endmodule

// File: tb/tb_sgd_rd_scheduler.sv
// Bench for sgd_rd_scheduler: config table, hand-built corner sequences and
// randomized runs checked against a loop-level model of the burst sequence.
module tb_sgd_rd_scheduler;
  localparam int BL = 8;
  localparam logic [63:0] A0 = 64'h0000_0000_1000_0000;
  localparam logic [63:0] B0 = 64'h0000_0000_2000_0000;

  typedef struct {
    logic [4:0]  id;
    logic [63:0] addr;
  } ar_t;

  typedef struct {
    logic [15:0] ne, nb, bb, ab;
    logic [63:0] abase, bbase;
    int          exp_n;
    logic [63:0] exp_last_addr;
    logic [4:0]  exp_last_id;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [63:0] a_base_addr, b_base_addr;
  logic [15:0] a_bpb, b_bpb, n_batches, n_epochs;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [4:0]  arid;
  logic        rsp_fire, rsp_last, af;
  logic        busy, done;
  logic [7:0]  outstanding;
  logic [31:0] perf;

  always #5 clk = ~clk;

  sgd_rd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base_addr(a_base_addr), .b_base_addr(b_base_addr),
    .a_bursts_per_batch(a_bpb), .b_bursts_per_batch(b_bpb),
    .num_batches(n_batches), .num_epochs(n_epochs),
    .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr),
    .m_axi_ARLEN(arlen), .m_axi_ARSIZE(arsize), .m_axi_ARBURST(arburst), .m_axi_ARID(arid),
    .rsp_fire(rsp_fire), .rsp_last(rsp_last), .dispatch_almost_full(af),
    .busy(busy), .done(done), .outstanding(outstanding), .perf_ar_stall_cycles(perf)
  );

  int total = 0, bad = 0;
  ar_t got[$], expq[$];
  int  pend = 0, beat = 0, credits = -1, stall_pct = 0;
  int  rdy_pct = 100, af_pct = 0;
  bit  manual = 0;
  int  done_cnt = 0;
  logic [7:0]  out_at_done = 0;
  logic [31:0] pm = 0, pm_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference sequence: nested epoch/batch loops, b bursts before a bursts.
  task automatic build_exp(input vec_t c);
    expq.delete();
    for (int e = 0; e < int'(c.ne); e++)
      for (int bt = 0; bt < int'(c.nb); bt++) begin
        for (int k = 0; k < int'(c.bb); k++)
          expq.push_back('{5'd2, c.bbase + 64'((bt * int'(c.bb) + k) * BL * 64)});
        for (int k = 0; k < int'(c.ab); k++)
          expq.push_back('{5'd1, c.abase + 64'((bt * int'(c.ab) + k) * BL * 64)});
      end
  endtask

  // R-channel responder: in-order 8-beat bursts, RLAST gated by credits.
  initial begin
    rsp_fire = 0; rsp_last = 0;
    forever begin
      @(negedge clk);
      rsp_fire = 0; rsp_last = 0;
      if (pend > 0 && credits != 0 && $urandom_range(0, 99) >= stall_pct) begin
        rsp_fire = 1; beat++;
        if (beat == BL) begin
          rsp_last = 1; beat = 0; pend--;
          if (credits > 0) credits--;
        end
      end
    end
  end

  // Random ARREADY / almost_full unless the test drives them directly.
  initial begin
    arready = 1; af = 0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        arready = ($urandom_range(0, 99) < rdy_pct);
        af      = ($urandom_range(0, 99) < af_pct);
      end
    end
  end

  // Monitor: capture handshakes and check protocol invariants every cycle.
  initial begin
    bit prev_v = 0, prev_r = 0, prev_hs = 0, prev_done = 0;
    logic [63:0] prev_a = 0;
    logic [4:0]  prev_id = 0;
    forever begin
      @(negedge clk); #1;
      pm_seen = pm;
      if (!rst_n) begin
        prev_v = 0; prev_r = 0; prev_hs = 0; prev_done = 0; pm = 0;
      end else begin
        if (prev_v && !prev_r) begin
          total++;
          if (!arvalid || araddr !== prev_a || arid !== prev_id) begin
            bad++;
            $display("FAIL ar_hold: got v=%0b a=%0h id=%0d want v=1 a=%0h id=%0d",
                     arvalid, araddr, arid, prev_a, prev_id);
          end
        end
        if (outstanding > 8'd4) chk("outstanding_max", outstanding, 4);
        if (done && prev_done) chk("done_pulse_width", 2, 1);
        if (done) begin done_cnt++; out_at_done = outstanding; end
        if (arvalid && arready) begin
          if (prev_hs) chk("issue_rate", 1, 0);
          got.push_back('{arid, araddr});
          pend++;
        end
        if (start && !busy) pm = 0;
        else if ((busy && !arvalid && (outstanding == 8'd4 || af)) || (arvalid && !arready))
          if (pm != 32'hFFFF_FFFF) pm++;
        prev_v = arvalid; prev_r = arready; prev_hs = arvalid && arready;
        prev_a = araddr; prev_id = arid; prev_done = done;
      end
    end
  end

  task automatic start_run(input vec_t c);
    build_exp(c);
    got.delete();
    a_base_addr = c.abase; b_base_addr = c.bbase;
    a_bpb = c.ab; b_bpb = c.bb; n_batches = c.nb; n_epochs = c.ne;
    cyc(); start = 1;
    cyc(); start = 0;
    // Config is captured at start; scrambling the inputs must not matter.
    a_base_addr = {$urandom, $urandom}; b_base_addr = {$urandom, $urandom};
    a_bpb = 16'($urandom); b_bpb = 16'($urandom);
    n_batches = 16'($urandom); n_epochs = 16'($urandom);
  endtask

  task automatic finish_run(input string nm, input bit poke);
    int  d0 = done_cnt;
    bit  ok = 0, safe = 0, bad_order = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      start = (poke && i == 3 && safe);
      #2;
      safe = busy && !done;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    cyc(); start = 0;
    chk({nm, "_done_seen"}, ok, 1);
    chk({nm, "_out_at_done"}, out_at_done, 0);
    chk({nm, "_n_bursts"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i].id !== expq[i].id || got[i].addr !== expq[i].addr) begin
        if (!bad_order) $display("FAIL %s_seq[%0d]: got id=%0d a=%0h want id=%0d a=%0h",
                                 nm, i, got[i].id, got[i].addr, expq[i].id, expq[i].addr);
        bad_order = 1;
      end
    total++;
    if (bad_order) bad++;
    #2;
    chk({nm, "_busy_after"}, busy, 0);
`ifdef SGD_RD_PERF_EN
    chk({nm, "_perf"}, perf, pm_seen);
`else
    chk({nm, "_perf"}, perf, 0);
`endif
  endtask

  vec_t tbl[8];
  vec_t c;

  initial begin
    tbl[0] = '{1, 2, 1, 3, A0, B0, 8, A0 + 64'hA00, 5'd1};
    tbl[1] = '{2, 1, 0, 2, A0, B0, 4, A0 + 64'h200, 5'd1};
    tbl[2] = '{0, 2, 1, 1, A0, B0, 0, 64'h0, 5'd0};
    tbl[3] = '{1, 0, 1, 1, A0, B0, 0, 64'h0, 5'd0};
    tbl[4] = '{2, 2, 2, 0, A0, B0, 8, B0 + 64'h600, 5'd2};
    tbl[5] = '{1, 1, 0, 0, A0, B0, 0, 64'h0, 5'd0};
    tbl[6] = '{1, 1, 0, 2, 64'hFFFF_FFFF_FFFF_FE00, B0, 2, 64'h0, 5'd1};
    tbl[7] = '{3, 2, 1, 1, A0, B0, 12, A0 + 64'h200, 5'd1};

    rst_n = 0; start = 0;
    a_base_addr = 0; b_base_addr = 0; a_bpb = 0; b_bpb = 0; n_batches = 0; n_epochs = 0;
    repeat (3) cyc();
    #2;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_perf", perf, 0);
    chk("arlen", arlen, 7);
    chk("arsize", arsize, 3'b110);
    chk("arburst", arburst, 2'b01);
    cyc(); rst_n = 1;

    // Config table with ideal slave.
    for (int t = 0; t < 8; t++) begin
      start_run(tbl[t]);
      finish_run($sformatf("tbl%0d", t), 0);
      chk($sformatf("tbl%0d_count", t), got.size(), tbl[t].exp_n);
      if (tbl[t].exp_n > 0 && got.size() > 0) begin
        chk($sformatf("tbl%0d_last_addr", t), got[got.size()-1].addr, tbl[t].exp_last_addr);
        chk($sformatf("tbl%0d_last_id", t), got[got.size()-1].id, tbl[t].exp_last_id);
      end
    end

    // RLAST withheld: credit limit, then one release per RLAST.
    c = '{1, 4, 1, 3, A0, B0, 16, 64'h0, 5'd0};
    credits = 0;
    start_run(c);
    repeat (40) cyc();
    #2;
    chk("bp_issued", got.size(), 4);
    chk("bp_outstanding", outstanding, 4);
    chk("bp_arvalid_low", arvalid, 0);
    cyc(); credits = 1;
    repeat (30) cyc();
    #2;
    chk("bp_one_more", got.size(), 5);
    chk("bp_out_full", outstanding, 4);
    cyc(); credits = 1;
    repeat (30) cyc();
    #2;
    chk("bp_two_more", got.size(), 6);
    cyc(); credits = -1;
    finish_run("bp", 0);

    // ARREADY held low while almost_full toggles.
    c = '{1, 1, 2, 2, A0, B0, 4, 64'h0, 5'd0};
    manual = 1; arready = 0; af = 0;
    start_run(c);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin cyc(); #2; seen = arvalid; end
      chk("hold_arvalid_rose", seen, 1);
    end
    chk("hold_first_addr", araddr, B0);
    chk("hold_first_id", arid, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(); af = i[0]; #2;
      chk("hold_valid", arvalid, 1);
      chk("hold_addr", araddr, B0);
    end
    cyc(); af = 1; arready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #2;
      chk("af_blocks_issue", arvalid, 0);
    end
    chk("af_one_issued", got.size(), 1);
    cyc(); manual = 0; rdy_pct = 100; af_pct = 0;
    finish_run("hold", 0);

    // num_epochs=0: immediate done; start during DONE is ignored.
    got.delete();
    n_epochs = 0; n_batches = 1; a_bpb = 1; b_bpb = 1;
    cyc(); start = 1;
    cyc(); start = 1; #2;
    chk("e0_busy", busy, 1);
    chk("e0_done", done, 1);
    cyc(); start = 0; #2;
    chk("e0_busy_clr", busy, 0);
    chk("e0_done_clr", done, 0);
    cyc(); #2;
    chk("e0_stays_idle", busy, 0);
    chk("e0_no_ar", got.size(), 0);

    // Reset mid-ISSUE_A with 3 bursts in flight.
    c = '{1, 1, 0, 8, A0, B0, 8, 64'h0, 5'd0};
    credits = 0;
    start_run(c);
    begin
      bit reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin cyc(); #2; reached = (got.size() == 3); end
      chk("mid_three_issued", reached, 1);
    end
    cyc(); #2;
    chk("mid_out3", outstanding, 3);
    cyc(); rst_n = 0; #2;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_arid", arid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_done", done, 0);
    cyc(); cyc(); rst_n = 1; credits = -1;
    begin
      bit nz = 0;
      for (int i = 0; i < 40; i++) begin cyc(); #2; if (outstanding != 0) nz = 1; end
      chk("late_rlast_sat", nz, 0);
    end
    start_run(tbl[0]);
    finish_run("after_rst", 0);

    // Randomized configs and slave behaviour, with stray starts mid-run.
    for (int r = 0; r < 12; r++) begin
      c.ne = 16'($urandom_range(0, 2)); c.nb = 16'($urandom_range(0, 3));
      c.bb = 16'($urandom_range(0, 3)); c.ab = 16'($urandom_range(0, 4));
      c.abase = {$urandom, $urandom[31:6], 6'd0};
      c.bbase = {$urandom, $urandom[31:6], 6'd0};
      c.exp_n = 0; c.exp_last_addr = 0; c.exp_last_id = 0;
      rdy_pct = $urandom_range(30, 100); af_pct = $urandom_range(0, 40);
      stall_pct = $urandom_range(0, 60);
      start_run(c);
      finish_run($sformatf("rnd%0d", r), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sgd_rd_scheduler.md
Name: sgd_rd_scheduler

Overview:
Read-request sequencer feeding sgd_dispatch. Per epoch and per mini-batch, it issues AXI4 read bursts for b (label) data tagged TAG_B, then a (sample) data tagged TAG_A. In-flight bursts are bounded by an outstanding-burst credit counter, and new bursts are throttled by the dispatch a-FIFO almost_full. It sits between the SGD control registers and the DDR4 AXI AR channel; R-channel beats go directly to sgd_dispatch.

Parameters:
ADDR_WIDTH, 64, AXI address width
ID_WIDTH, 5, AXI ARID width
BURST_LEN, 8, beats per burst; ARLEN = BURST_LEN-1; address stride = BURST_LEN*64 bytes
MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed (RLAST)
TAG_A, 1, ARID for a-data bursts
TAG_B, 2, ARID for b-data bursts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; samples config; ignored while busy
a_base_addr  in  ADDR_WIDTH  a-data base address (64B aligned)
b_base_addr  in  ADDR_WIDTH  b-data base address (64B aligned)
a_bursts_per_batch  in  16  a bursts per mini-batch
b_bursts_per_batch  in  16  b bursts per mini-batch
num_batches  in  16  mini-batches per epoch
num_epochs  in  16  epochs
m_axi_ARVALID  out  1  address valid
m_axi_ARREADY  in  1  address ready
m_axi_ARADDR  out  ADDR_WIDTH  burst address
m_axi_ARLEN  out  8  BURST_LEN-1, constant
m_axi_ARSIZE  out  3  3'b110, constant
m_axi_ARBURST  out  2  2'b01 INCR, constant
m_axi_ARID  out  ID_WIDTH  TAG_A or TAG_B
rsp_fire  in  1  RVALID&RREADY observed on the R channel
rsp_last  in  1  RLAST
dispatch_almost_full  in  1  a-FIFO almost_full from dispatch
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at completion
outstanding  out  8  bursts currently in flight
perf_ar_stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, any cycle including mid-run): FSM=IDLE; ARVALID=0, ARADDR=0, ARID=0, busy=0, done=0, outstanding=0, all internal counters 0. Bursts in flight at reset are abandoned; their later RLASTs must not underflow outstanding (saturate at 0).
- FSM states: IDLE, ISSUE_B, ISSUE_A, NEXT_BATCH, NEXT_EPOCH, DRAIN, DONE.
- IDLE: on start, register all config; busy<=1; set a_ptr=a_base_addr and b_ptr=b_base_addr; clear batch_cnt and epoch_cnt.
  - If num_epochs==0 or num_batches==0 -> DONE.
  - Else if b_bursts_per_batch!=0 -> ISSUE_B; else -> ISSUE_A.
- Issue rule, ISSUE_B and ISSUE_A:
  - ARVALID rises only when ~ARVALID & outstanding<MAX_OUTSTANDING & ~dispatch_almost_full.
  - Once high, ARVALID/ARADDR/ARID hold stable until ARREADY; no withdrawal even if almost_full rises.
  - On handshake: ptr += BURST_LEN*64; burst_cnt++; ARVALID drops for at least one cycle. Maximum issue rate is one burst per 2 cycles.
- ISSUE_B: after b_bursts_per_batch handshakes -> ISSUE_A, or NEXT_BATCH if a_bursts_per_batch==0.
- ISSUE_A: after a_bursts_per_batch handshakes -> NEXT_BATCH.
- NEXT_BATCH (1 cycle): batch_cnt++.
  - If batch_cnt==num_batches-1 -> NEXT_EPOCH.
  - Else -> ISSUE_B (or ISSUE_A if b count is 0).
- NEXT_EPOCH (1 cycle): epoch_cnt++; a_ptr and b_ptr reload from base; batch_cnt=0.
  - If last epoch -> DRAIN.
  - Else -> the first issue state.
- DRAIN: wait until outstanding==0 -> DONE.
- DONE: done=1 for one cycle; busy<=0 -> IDLE.
- outstanding: +1 on AR handshake, -1 on rsp_fire&rsp_last; both in the same cycle -> unchanged. Never exceeds MAX_OUTSTANDING.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters are 16-bit, compared unsigned.
- A start pulse coincident with done is ignored.

Optional Feature:
SGD_RD_PERF_EN
- Defined: perf_ar_stall_cycles counts cycles with busy & ~ARVALID & (outstanding==MAX_OUTSTANDING | dispatch_almost_full), plus cycles with ARVALID & ~ARREADY. Cleared on reset and on accepted start; saturates at 32'hFFFFFFFF.
- Not defined: perf_ar_stall_cycles tied to 0 and the counter logic is omitted.

Test Plan:
- Config epochs=1, batches=2, b=1, a=3, ARREADY=1, R returns immediately -> 8 bursts, ID order B,A,A,A,B,A,A,A; a addresses base, +0x200, +0x400, +0x600 ...; done pulse after the last RLAST.
- Hold rsp_last=0 -> exactly 4 ARs issued then ARVALID stays 0; outstanding==4. Each single RLAST releases exactly one more AR.
- ARREADY=0 for 10 cycles while dispatch_almost_full toggles -> ARVALID and ARADDR stable throughout; after almost_full=1, no new ARVALID rises.
- epochs=2, batches=1, a=2, b=0 -> 4 A bursts at a_base, a_base+0x200, a_base, a_base+0x200 (pointer reloads per epoch).
- num_epochs=0 -> no ARVALID; busy for 1 cycle, then done pulse; start during busy is ignored.
- Assert rst_n=0 mid-ISSUE_A with 3 bursts outstanding -> outputs return to 0 immediately. Late RLASTs keep outstanding at 0, and a new start runs the full sequence correctly.
